bit_serializer: RTL

//  Parallel-to-serial front end for the sequence detectors: accepts DATA_W-bit words on a

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_serializer_tick_gen.sv | 50 +++++
 rtl/bit_serializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and bit counter sizing.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter wide enough to index every bit of a word; never narrower than 1.
  function automatic int bit_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_tick_gen.sv
// Bit-period generator: latches the period on word load and flags the last cycle
// of each bit; registers the strobe marking the first cycle of each new bit.
module bit_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             last_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             eob_o,
  output logic             bit_stb_o
);

  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;

  assign eob_o     = run_i && (cnt_q == per_q);
  assign bit_stb_o = stb_q;

  always_comb begin
    per_d = per_q;
    cnt_d = '0;
    stb_d = 1'b0;
    if (load_i) begin
      per_d = div_i;
      stb_d = 1'b1;
    end else if (eob_o) begin
      // Next bit starts unless this was the final bit going idle.
      stb_d = !last_i;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q <= '0;
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with a one-word holding register for gap-free
// back-to-back words; all outputs registered.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   DIV_W     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic              ser_out_o,
  output logic              bit_stb_o,
  output logic              busy_o,
  output logic              underrun_o
);

  localparam int             BCW      = bit_cnt_w(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              ser_q, ser_d;
  logic              ready_q;
  logic              busy_q;
  logic              unr_q, unr_d;

  logic              xfer, eob, last, load;
  logic [DATA_W-1:0] load_word;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign xfer = s_valid_i && ready_q;
  assign last = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    ser_d       = ser_q;
    unr_d       = 1'b0;
    load        = 1'b0;
    load_word   = s_data_i;

    case (state_q)
      IDLE: begin
        ser_d = IDLE_LVL;
        load  = xfer;
      end
      SHIFT: begin
        if (eob && last) begin
          // Word boundary: chain the held word, else a word arriving right now.
          if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            ser_d   = IDLE_LVL;
            unr_d   = 1'b1;
          end
        end else begin
          if (eob) begin
            shift_d   = advance(shift_q);
            ser_d     = head(advance(shift_q));
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (xfer) begin
            hold_d      = s_data_i;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = SHIFT;
      shift_d   = load_word;
      ser_d     = head(load_word);
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      ser_q       <= IDLE_LVL;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_q       <= ser_d;
      ready_q     <= !hold_full_d;
      busy_q      <= (state_d == SHIFT);
      unr_q       <= unr_d;
    end
  end

  bit_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .run_i     (state_q == SHIFT),
    .last_i    (last),
    .div_i     (div_i),
    .eob_o     (eob),
    .bit_stb_o (bit_stb_o)
  );

  assign s_ready_o  = ready_q;
  assign ser_out_o  = ser_q;
  assign busy_o     = busy_q;
  assign underrun_o = unr_q;

endmodule
